// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and op decode helpers for the
// sequential multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Control-unit side bus of the multiply/divide unit. Handshake: start is
// sampled only while idle; done is a one-cycle pulse, after which hi/lo hold.
interface muldiv_seq_if #(parameter int WIDTH = 32);
   import muldiv_pkg::*;

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;
   state_t           state;

   modport master (output start, op, a, b,
                   input  busy, done, hi, lo, div_zero, state);
   modport slave  (input  start, op, a, b,
                   output busy, done, hi, lo, div_zero, state);

endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation; used both to take operand
// magnitudes and to restore the sign of results.
module muldiv_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] x,
   input  logic         neg,
   output logic [W-1:0] y
);

   assign y = neg ? -x : x;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed/unsigned multiply and restoring divide, one bit per
// cycle, with start/busy/done handshake and divide-by-zero reporting.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_seq_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state, state_nxt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb;
   logic [CNT_W-1:0]   cnt;
   logic               is_div_r, neg_res, neg_rem, dz_r;
   logic [WIDTH-1:0]   hi_r, lo_r;
   logic               busy, done;

   logic               sgn_in, b_zero;
   logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
   logic [2*WIDTH-1:0] prod_fix, acc_step;
   logic [WIDTH:0]     add_sum, shifted, trial;

   assign sgn_in = op_is_signed(bus.op);
   assign b_zero = (bus.b == '0);

   muldiv_sign_fix #(.W(WIDTH)) u_a_mag (
      .x(bus.a), .neg(sgn_in & bus.a[WIDTH-1]), .y(a_mag));
   muldiv_sign_fix #(.W(WIDTH)) u_b_mag (
      .x(bus.b), .neg(sgn_in & bus.b[WIDTH-1]), .y(b_mag));
   muldiv_sign_fix #(.W(2*WIDTH)) u_prod (
      .x(acc), .neg(neg_res), .y(prod_fix));
   muldiv_sign_fix #(.W(WIDTH)) u_quo (
      .x(acc[WIDTH-1:0]), .neg(neg_res), .y(quo_fix));
   muldiv_sign_fix #(.W(WIDTH)) u_rem (
      .x(acc[2*WIDTH-1:WIDTH]), .neg(neg_rem), .y(rem_fix));

   // acc holds {partial product, multiplier} for MULT and
   // {remainder, dividend/quotient} for DIV; both shift once per cycle.
   always_comb begin
      add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      shifted  = acc[2*WIDTH-1:WIDTH-1];
      trial    = shifted - {1'b0, opb};
      acc_step = {add_sum, acc[WIDTH-1:1]};
      if (is_div_r) begin
         if (trial[WIDTH])
            acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         else
            acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
   end

   // A divide by zero still passes through FIX (without writing hi/lo) so
   // that done lands two cycles after the start edge.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (bus.start)
                  state_nxt = (op_is_div(bus.op) && b_zero) ? FIX : RUN;
         RUN: begin
            busy = 1'b1;
            if (cnt == CNT_W'(1)) state_nxt = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= '0;
         opb      <= '0;
         cnt      <= '0;
         is_div_r <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         dz_r     <= 1'b0;
         hi_r     <= '0;
         lo_r     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (bus.start) begin
               acc      <= {{WIDTH{1'b0}}, a_mag};
               opb      <= b_mag;
               cnt      <= CNT_W'(WIDTH);
               is_div_r <= op_is_div(bus.op);
               neg_res  <= sgn_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               neg_rem  <= sgn_in & bus.a[WIDTH-1];
               dz_r     <= op_is_div(bus.op) & b_zero;
            end
            RUN: begin
               acc <= acc_step;
               cnt <= cnt - CNT_W'(1);
            end
            FIX: if (!dz_r) begin
               if (is_div_r) begin
                  hi_r <= rem_fix;
                  lo_r <= quo_fix;
               end else begin
                  {hi_r, lo_r} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.hi       = hi_r;
   assign bus.lo       = lo_r;
   assign bus.div_zero = dz_r & (state == FIX || state == DONE || state == IDLE);
   assign bus.state    = state;

endmodule
